// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Start bit 0, eight payload bits LSB-first,
// stop bit 1. The transmitter drives the payload inverted, so the byte is
// re-inverted on output when INVERT_PAYLOAD=1.
// Optional macro UART_RX_MAJORITY_EN: every sample is a 2-of-3 vote over
// counter limit-1, limit and limit+1, and each decision lands one clk later.
module uart_rx #(
  parameter int BAUD_RATE      = 115_200,
  parameter int CLOCK_SPEED    = 50_000_000,
  parameter int BAUD_WIDTH     = CLOCK_SPEED / BAUD_RATE,
  parameter bit INVERT_PAYLOAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

`ifdef UART_RX_MAJORITY_EN
  // One extra count is needed to reach the limit+1 vote cycle.
  localparam int CW = $clog2(BAUD_WIDTH + 1);
  // The vote finishes one cycle past the limit, so the next period starts
  // at 1 to keep the sample centres on the nominal half-bit grid.
  localparam logic [CW-1:0] CNT_RESTART = CW'(1);
`else
  localparam int CW = $clog2(BAUD_WIDTH);
  localparam logic [CW-1:0] CNT_RESTART = '0;
`endif

  localparam logic [CW-1:0] START_LIM = CW'(BAUD_WIDTH / 2 - 1);
  localparam logic [CW-1:0] BIT_LIM   = CW'(BAUD_WIDTH - 1);

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    START     = 5'b00010,
    DATA      = 5'b00100,
    STOP      = 5'b01000,
    WAIT_IDLE = 5'b10000
  } state_t;

  logic          sync1_q, sync2_q, prev_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] lim;
  logic          evt;
  logic          samp;

  assign rx_s = sync2_q;

  // Cycle limit of the current bit period: half a bit for START, full otherwise.
  always_comb begin
    lim = (state_q == START) ? START_LIM : BIT_LIM;
  end

`ifdef UART_RX_MAJORITY_EN
  logic s1_q, s1_d, s2_q, s2_d;

  // Capture the two early votes and decide on the limit+1 cycle.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (cnt_q == lim - CW'(1)) s1_d = rx_s;
    if (cnt_q == lim)          s2_d = rx_s;
    evt  = (cnt_q == lim + CW'(1));
    samp = (s1_q & s2_q) | (s1_q & rx_s) | (s2_q & rx_s);
  end

  // Vote flops; contents only matter within a bit period, so reset to idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
`else
  // Single sample taken at the counter limit.
  always_comb begin
    evt  = (cnt_q == lim);
    samp = rx_s;
  end
`endif

  // Two-flop synchronizer plus one history flop for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame sequencing: next state, counters, shift register and output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (evt) begin
          if (!samp) begin
            state_d = DATA;
            cnt_d   = CNT_RESTART;
            bit_d   = 3'd0;
          end else begin
            // Line bounced back high before mid-start: not a frame.
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (evt) begin
          shift_d[bit_q] = samp;
          cnt_d          = CNT_RESTART;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (evt) begin
          cnt_d = '0;
          if (samp) begin
            // Back to IDLE mid-stop-bit so a zero-gap next start is caught.
            state_d    = IDLE;
            data_d     = INVERT_PAYLOAD ? ~shift_q : shift_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d     = WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        // A held break reports one error only; wait for the line to recover.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any partial frame silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
